// File: rtl/axil_lb_pkg.sv
// Shared definitions for the AXI4-Lite to local-bus bridge: FSM state
// encoding, AXI response codes and the read-delay counter width.
package axil_lb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      WRESP = 3'd2,
      READ  = 3'd3,
      RRESP = 3'd4
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Wide enough for the largest legal local-bus read delay (15).
   localparam int CNT_W = 4;

endpackage

// File: rtl/axil_lb_bridge_if.sv
// AXI4-Lite slave-port signal bundle for axil_lb_bridge. Signal names keep
// the s00_axi_ prefix so they line up with the AXI port names of the block.
interface axil_lb_bridge_if #(
   parameter int LB_DATAWIDTH = 32,
   parameter int LB_ADDRWIDTH = 16
);
   logic [LB_ADDRWIDTH+1:0]   s00_axi_awaddr;
   logic                      s00_axi_awvalid;
   logic                      s00_axi_awready;
   logic [LB_DATAWIDTH-1:0]   s00_axi_wdata;
   logic [LB_DATAWIDTH/8-1:0] s00_axi_wstrb;
   logic                      s00_axi_wvalid;
   logic                      s00_axi_wready;
   logic [1:0]                s00_axi_bresp;
   logic                      s00_axi_bvalid;
   logic                      s00_axi_bready;
   logic [LB_ADDRWIDTH+1:0]   s00_axi_araddr;
   logic                      s00_axi_arvalid;
   logic                      s00_axi_arready;
   logic [LB_DATAWIDTH-1:0]   s00_axi_rdata;
   logic [1:0]                s00_axi_rresp;
   logic                      s00_axi_rvalid;
   logic                      s00_axi_rready;

   modport slave (
      input  s00_axi_awaddr, s00_axi_awvalid, s00_axi_wdata, s00_axi_wstrb,
             s00_axi_wvalid, s00_axi_bready, s00_axi_araddr, s00_axi_arvalid,
             s00_axi_rready,
      output s00_axi_awready, s00_axi_wready, s00_axi_bresp, s00_axi_bvalid,
             s00_axi_arready, s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
   );

   modport master (
      output s00_axi_awaddr, s00_axi_awvalid, s00_axi_wdata, s00_axi_wstrb,
             s00_axi_wvalid, s00_axi_bready, s00_axi_araddr, s00_axi_arvalid,
             s00_axi_rready,
      input  s00_axi_awready, s00_axi_wready, s00_axi_bresp, s00_axi_bvalid,
             s00_axi_arready, s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
   );
endinterface

// File: rtl/lb_read_delay.sv
// Loadable down-counter timing the local-bus read latency. Loading DELAY on
// the read handshake makes done rise exactly DELAY cycles after the lb_read
// pulse cycle.
module lb_read_delay
   import axil_lb_pkg::*;
#(
   parameter int DELAY = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic done
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load on request, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CNT_W'(DELAY);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   // NOTE: sequential state uses non-blocking assignment so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/axil_lb_bridge.sv
// AXI4-Lite slave to simple local-bus bridge, one transaction in flight.
// Writes win over simultaneous reads. Optional build macro
// AXIL_LB_WSTRB_CHECK_EN rejects partial-strobe writes with SLVERR and no
// lb_write; without it wstrb is ignored.
module axil_lb_bridge
   import axil_lb_pkg::*;
#(
   parameter int LB_DATAWIDTH  = 32,
   parameter int LB_ADDRWIDTH  = 16,
   parameter int LB_READ_DELAY = 3
) (
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_aresetn,
   axil_lb_bridge_if.slave         s_axi,
   output logic [LB_ADDRWIDTH-1:0] lb_addr,
   output logic [LB_DATAWIDTH-1:0] lb_wdata,
   output logic                    lb_write,
   output logic                    lb_read,
   input  logic [LB_DATAWIDTH-1:0] lb_rdata
);

   state_e                  state_q, state_d;
   logic [LB_ADDRWIDTH-1:0] lb_addr_q, lb_addr_d;
   logic [LB_DATAWIDTH-1:0] lb_wdata_q, lb_wdata_d;
   logic                    lb_write_q, lb_write_d;
   logic                    lb_read_q, lb_read_d;
   logic [LB_DATAWIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]              bresp_q, bresp_d;
   logic                    wr_req, strb_ok, rd_load, rd_done;

   assign wr_req = s_axi.s00_axi_awvalid & s_axi.s00_axi_wvalid;

`ifdef AXIL_LB_WSTRB_CHECK_EN
   assign strb_ok = &s_axi.s00_axi_wstrb;
`else
   logic unused_wstrb;
   assign unused_wstrb = ^s_axi.s00_axi_wstrb;
   assign strb_ok      = 1'b1;
`endif

   // Handshake outputs decode straight from the state register; AW and W
   // are only accepted together, and AR only when no full write is offered.
   assign s_axi.s00_axi_awready = (state_q == IDLE) & wr_req;
   assign s_axi.s00_axi_wready  = (state_q == IDLE) & wr_req;
   assign s_axi.s00_axi_arready = (state_q == IDLE) & s_axi.s00_axi_arvalid & ~wr_req;
   assign s_axi.s00_axi_bvalid  = (state_q == WRESP);
   assign s_axi.s00_axi_rvalid  = (state_q == RRESP);
   assign s_axi.s00_axi_bresp   = bresp_q;
   assign s_axi.s00_axi_rresp   = RESP_OKAY;
   assign s_axi.s00_axi_rdata   = rdata_q;

   assign lb_addr  = lb_addr_q;
   assign lb_wdata = lb_wdata_q;
   assign lb_write = lb_write_q;
   assign lb_read  = lb_read_q;

   lb_read_delay #(.DELAY(LB_READ_DELAY)) u_rd_delay (
      .clk   (s00_axi_aclk),
      .rst_n (s00_axi_aresetn),
      .load  (rd_load),
      .done  (rd_done)
   );

   // Next-state and registered-output logic for the transaction FSM.
   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      lb_addr_d  = lb_addr_q;
      lb_wdata_d = lb_wdata_q;
      lb_write_d = 1'b0;
      lb_read_d  = 1'b0;
      rdata_d    = rdata_q;
      bresp_d    = bresp_q;
      rd_load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wr_req) begin
               lb_addr_d  = s_axi.s00_axi_awaddr[LB_ADDRWIDTH+1:2];
               lb_wdata_d = s_axi.s00_axi_wdata;
               if (strb_ok) begin
                  lb_write_d = 1'b1;
                  bresp_d    = RESP_OKAY;
                  state_d    = WRITE;
               end else begin
                  bresp_d    = RESP_SLVERR;
                  state_d    = WRESP;
               end
            end else if (s_axi.s00_axi_arvalid) begin
               lb_addr_d = s_axi.s00_axi_araddr[LB_ADDRWIDTH+1:2];
               lb_read_d = 1'b1;
               rd_load   = 1'b1;
               state_d   = READ;
            end
         end
         WRITE: state_d = WRESP;
         WRESP: if (s_axi.s00_axi_bready) state_d = IDLE;
         READ: begin
            if (rd_done) begin
               rdata_d = lb_rdata;
               state_d = RRESP;
            end
         end
         RRESP: if (s_axi.s00_axi_rready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_q    <= IDLE;
         lb_addr_q  <= '0;
         lb_wdata_q <= '0;
         lb_write_q <= 1'b0;
         lb_read_q  <= 1'b0;
         rdata_q    <= '0;
         bresp_q    <= RESP_OKAY;
      end else begin
         state_q    <= state_d;
         lb_addr_q  <= lb_addr_d;
         lb_wdata_q <= lb_wdata_d;
         lb_write_q <= lb_write_d;
         lb_read_q  <= lb_read_d;
         rdata_q    <= rdata_d;
         bresp_q    <= bresp_d;
      end
   end

endmodule

// File: tb/tb_axil_lb_bridge.sv
// Directed bench for axil_lb_bridge (LB_READ_DELAY = 3). Honours
// AXIL_LB_WSTRB_CHECK_EN for the partial-strobe write expectations.
module tb_axil_lb_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] lb_addr;
   logic [31:0] lb_wdata;
   logic        lb_write;
   logic        lb_read;
   logic [31:0] lb_rdata;
   int          n_vec = 0;
   int          n_err = 0;

   localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

   axil_lb_bridge_if #(.LB_DATAWIDTH(32), .LB_ADDRWIDTH(16)) bus ();

   axil_lb_bridge #(.LB_DATAWIDTH(32), .LB_ADDRWIDTH(16), .LB_READ_DELAY(3)) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .s_axi           (bus),
      .lb_addr         (lb_addr),
      .lb_wdata        (lb_wdata),
      .lb_write        (lb_write),
      .lb_read         (lb_read),
      .lb_rdata        (lb_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_model(input logic [15:0] a);
      return (a == 16'h0002) ? 32'h1234_5678 : {16'hA5A5, a};
   endfunction

   // Local-bus slave model: data valid 3 cycles after the lb_read pulse cycle.
   logic [1:0]  m_cnt;
   logic [15:0] m_addr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 2'd0; m_addr <= '0; lb_rdata <= JUNK;
      end else if (lb_read) begin
         m_cnt <= 2'd2; m_addr <= lb_addr; lb_rdata <= JUNK;
      end else if (m_cnt == 2'd1) begin
         m_cnt <= 2'd0; lb_rdata <= rd_model(m_addr);
      end else if (m_cnt != 2'd0) begin
         m_cnt <= m_cnt - 2'd1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.s00_axi_awaddr = '0; bus.s00_axi_awvalid = 1'b0;
      bus.s00_axi_wdata = '0;  bus.s00_axi_wstrb = 4'hF; bus.s00_axi_wvalid = 1'b0;
      bus.s00_axi_bready = 1'b0;
      bus.s00_axi_araddr = '0; bus.s00_axi_arvalid = 1'b0; bus.s00_axi_rready = 1'b0;
   endtask

   // Full read from an idle bridge; optionally hold rready low for lag cycles.
   task automatic read_txn(input logic [17:0] addr, input int lag);
      int n;
      logic [31:0] exp;
      exp = rd_model(addr[17:2]);
      bus.s00_axi_araddr = addr; bus.s00_axi_arvalid = 1'b1; bus.s00_axi_rready = 1'b0;
      #1;
      check("rd_arready", bus.s00_axi_arready, 1);
      tick();
      bus.s00_axi_arvalid = 1'b0;
      check("rd_lb_read_pulse", lb_read, 1);
      check("rd_lb_addr", lb_addr, addr[17:2]);
      n = 0;
      while (!bus.s00_axi_rvalid && n < 20) begin
         tick();
         n++;
         check("rd_lb_read_single", lb_read, 0);
      end
      check("rd_rvalid_latency", n, 4);
      check("rd_rdata", bus.s00_axi_rdata, exp);
      check("rd_rresp", bus.s00_axi_rresp, 0);
      if (lag > 0) begin
         bus.s00_axi_araddr = 18'h40; bus.s00_axi_arvalid = 1'b1;
         for (int i = 0; i < lag; i++) begin
            tick();
            check("hold_rvalid", bus.s00_axi_rvalid, 1);
            check("hold_rdata", bus.s00_axi_rdata, exp);
            check("hold_arready", bus.s00_axi_arready, 0);
         end
         bus.s00_axi_arvalid = 1'b0;
      end
      bus.s00_axi_rready = 1'b1;
      tick();
      check("rd_rvalid_drop", bus.s00_axi_rvalid, 0);
      bus.s00_axi_rready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic bad;
      idle_inputs();
      tick(); tick();
      // Reset state
      check("rst_ready", {bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_arready}, 0);
      check("rst_valid", {bus.s00_axi_bvalid, bus.s00_axi_rvalid}, 0);
      check("rst_lb_strobes", {lb_write, lb_read}, 0);
      check("rst_lb_addr", lb_addr, 0);
      check("rst_lb_wdata", lb_wdata, 0);
      check("rst_rdata", bus.s00_axi_rdata, 0);
      check("rst_resp", {bus.s00_axi_bresp, bus.s00_axi_rresp}, 0);
      rst_n = 1'b1;
      tick();

      // Basic write: addr 0x10, data 0xDEADBEEF
      bus.s00_axi_awaddr = 18'h10; bus.s00_axi_wdata = 32'hDEAD_BEEF;
      bus.s00_axi_awvalid = 1'b1; bus.s00_axi_wvalid = 1'b1; bus.s00_axi_bready = 1'b1;
      #1;
      check("wr_awready", bus.s00_axi_awready, 1);
      check("wr_wready", bus.s00_axi_wready, 1);
      check("wr_arready", bus.s00_axi_arready, 0);
      tick();
      bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wvalid = 1'b0;
      check("wr_lb_write_n1", lb_write, 1);
      check("wr_lb_addr", lb_addr, 16'h0004);
      check("wr_lb_wdata", lb_wdata, 32'hDEAD_BEEF);
      check("wr_bvalid_n1", bus.s00_axi_bvalid, 0);
      tick();
      check("wr_lb_write_n2", lb_write, 0);
      check("wr_bvalid_n2", bus.s00_axi_bvalid, 1);
      check("wr_bresp", bus.s00_axi_bresp, 0);
      tick();
      check("wr_bvalid_drop", bus.s00_axi_bvalid, 0);
      bus.s00_axi_bready = 1'b0;

      // Basic read: addr 0x08 returns 0x12345678
      read_txn(18'h08, 0);

      // Simultaneous write and read: write first, read after B handshake
      bus.s00_axi_awaddr = 18'h20; bus.s00_axi_wdata = 32'hCAFE_F00D;
      bus.s00_axi_awvalid = 1'b1; bus.s00_axi_wvalid = 1'b1;
      bus.s00_axi_araddr = 18'h08; bus.s00_axi_arvalid = 1'b1;
      #1;
      check("sim_awready", bus.s00_axi_awready, 1);
      check("sim_arready_blocked", bus.s00_axi_arready, 0);
      tick();
      bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wvalid = 1'b0;
      check("sim_lb_write", lb_write, 1);
      check("sim_lb_read", lb_read, 0);
      check("sim_arready_write", bus.s00_axi_arready, 0);
      tick();
      check("sim_bvalid", bus.s00_axi_bvalid, 1);
      check("sim_arready_wresp", bus.s00_axi_arready, 0);
      tick();
      check("sim_bvalid_held", bus.s00_axi_bvalid, 1);
      bus.s00_axi_bready = 1'b1;
      #1;
      check("sim_arready_b_hs", bus.s00_axi_arready, 0);
      tick();
      bus.s00_axi_bready = 1'b0;
      check("sim_bvalid_drop", bus.s00_axi_bvalid, 0);
      read_txn(18'h08, 0);

      // rready held low for 10 cycles
      read_txn(18'h14, 10);

      // Reset during the read wait
      bus.s00_axi_araddr = 18'h0C; bus.s00_axi_arvalid = 1'b1;
      tick();
      bus.s00_axi_arvalid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("rrst_strobes", {lb_write, lb_read}, 0);
      check("rrst_valids", {bus.s00_axi_bvalid, bus.s00_axi_rvalid}, 0);
      check("rrst_lb_addr", lb_addr, 0);
      check("rrst_rdata", bus.s00_axi_rdata, 0);
      tick();
      rst_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.s00_axi_rvalid || lb_read || lb_write) bad = 1'b1;
      end
      check("rrst_no_activity", bad, 0);
      read_txn(18'h10, 0);

      // Partial write strobe
      bus.s00_axi_awaddr = 18'h30; bus.s00_axi_wdata = 32'h1111_2222; bus.s00_axi_wstrb = 4'b0011;
      bus.s00_axi_awvalid = 1'b1; bus.s00_axi_wvalid = 1'b1; bus.s00_axi_bready = 1'b1;
      #1;
      check("strb_awready", bus.s00_axi_awready, 1);
      tick();
      bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wvalid = 1'b0; bus.s00_axi_wstrb = 4'hF;
`ifdef AXIL_LB_WSTRB_CHECK_EN
      check("strb_no_lb_write", lb_write, 0);
      check("strb_bvalid", bus.s00_axi_bvalid, 1);
      check("strb_bresp", bus.s00_axi_bresp, 2'b10);
`else
      check("strb_lb_write", lb_write, 1);
      check("strb_lb_addr", lb_addr, 16'h000C);
      tick();
      check("strb_bvalid", bus.s00_axi_bvalid, 1);
      check("strb_bresp", bus.s00_axi_bresp, 2'b00);
`endif
      tick();
      check("strb_bvalid_drop", bus.s00_axi_bvalid, 0);
      bus.s00_axi_bready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axil_lb_bridge.md
AXIL_LB_BRIDGE -- requirements
Module: axil_lb_bridge

Interface
REQ-001 SHALL have parameter LB_DATAWIDTH, default 32, local-bus and AXI4-Lite data width.
REQ-002 SHALL have parameter LB_ADDRWIDTH, default 16, local-bus word-address width.
REQ-003 SHALL have parameter LB_READ_DELAY, default 3, cycles from lb_read pulse to valid lb_rdata (legal range 1..15).
REQ-004 SHALL have port s00_axi_aclk, input, 1, sole clock.
REQ-005 SHALL have port s00_axi_aresetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports s00_axi_awaddr/araddr, input, LB_ADDRWIDTH+2, byte addresses.
REQ-007 SHALL have ports s00_axi_awvalid/wvalid/arvalid/bready/rready, input, 1, AXI4-Lite handshakes.
REQ-008 SHALL have ports s00_axi_awready/wready/arready/bvalid/rvalid, output, 1, AXI4-Lite handshakes.
REQ-009 SHALL have port s00_axi_wdata, input, LB_DATAWIDTH, and s00_axi_wstrb, input, LB_DATAWIDTH/8.
REQ-010 SHALL have ports s00_axi_bresp/rresp, output, 2, and s00_axi_rdata, output, LB_DATAWIDTH.
REQ-011 SHALL have outputs lb_addr (LB_ADDRWIDTH), lb_wdata (LB_DATAWIDTH), lb_write (1), lb_read (1); input lb_rdata (LB_DATAWIDTH).

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, WRESP, READ, RRESP.
REQ-013 In IDLE, SHALL assert awready and wready together only when awvalid and wvalid are both high; handshake moves to WRITE.
REQ-014 In IDLE, SHALL assert arready only when arvalid high and (awvalid and wvalid) not both high; write wins simultaneous requests.
REQ-015 SHALL register lb_addr = addr[LB_ADDRWIDTH+1:2] and lb_wdata on the accepting handshake; byte-address bits [1:0] ignored.
REQ-016 WRITE SHALL last exactly one cycle with lb_write=1, then go to WRESP.
REQ-017 WRESP SHALL hold bvalid=1 until bready; bvalid&bready returns to IDLE the next cycle.
REQ-018 READ SHALL pulse lb_read for its first cycle only, count LB_READ_DELAY cycles, capture lb_rdata into rdata at cycle LB_READ_DELAY after the pulse, and enter RRESP.
REQ-019 RRESP SHALL hold rvalid=1 and stable rdata until rready; handshake returns to IDLE.
REQ-020 SHALL never have lb_write and lb_read high in the same cycle; at most one transaction outstanding.
REQ-021 Write latency SHALL be: handshake cycle N, lb_write at N+1, bvalid at N+2.
REQ-022 Read latency SHALL be: handshake N, lb_read at N+1, rvalid at N+2+LB_READ_DELAY.
REQ-023 bresp/rresp SHALL be 2'b00 except as REQ-028 states.

Reset
REQ-024 Reset low SHALL asynchronously force IDLE; all ready/valid outputs, lb_write, lb_read, lb_addr, lb_wdata, rdata, bresp, rresp = 0.
REQ-025 Reset mid-transaction SHALL abandon it without lb_write/lb_read pulse; first cycle after release is IDLE.

Configuration
REQ-026 Macro AXIL_LB_WSTRB_CHECK_EN SHALL select write-strobe checking.
REQ-027 Without macro: wstrb ignored; every accepted write issues lb_write with bresp=OKAY.
REQ-028 With macro: wstrb not all ones SHALL skip WRITE (no lb_write), go directly to WRESP with bresp=2'b10 (SLVERR).

Structure
REQ-029 Shared package axil_lb_pkg SHALL hold FSM state encoding and AXI response constants (OKAY=2'b00, SLVERR=2'b10).
REQ-030 Sub-module lb_read_delay (loadable down-counter, done flag) SHALL implement the READ wait; rest is one module.

Verification
REQ-031 Write addr 0x0010 data 0xDEADBEEF, bready=1 -> lb_addr=0x0004, lb_wdata=0xDEADBEEF, lb_write one cycle at N+1, bvalid at N+2, bresp=0.
REQ-032 Read addr 0x0008, lb_rdata model returns 0x12345678 after 3 cycles -> lb_read one pulse, rdata=0x12345678, rvalid at N+5.
REQ-033 AW/W and AR valid same cycle -> write completes first; read accepted only after bvalid&bready.
REQ-034 rready held low 10 cycles -> rvalid and rdata stable, arready=0 throughout.
REQ-035 Reset asserted during READ wait -> all outputs 0 immediately, no rvalid after release.
REQ-036 With AXIL_LB_WSTRB_CHECK_EN, wstrb=4'b0011 -> no lb_write, bresp=2'b10; without macro -> lb_write, bresp=0.
